eda_pixel_scanner: RTL and testbench

Raster-scan scheduler that feeds the regional-max controller with the next seed pixel. After `start` it walks the image in row-major order and skips pixels already flagged in the visited RAM. It presents each unvisited pixel as `{next_row, next_col}` with `next_valid`, then advances when the controller consumes it via `update_strb`. After the last pixel it raises `iterated_all`. It sits between the top-level frame control, the visited-flag RAM and the controller.

---
 rtl/eda_pixel_scanner_pkg.sv | 16 +
 rtl/eda_scan_counter.sv | 74 +++++++
 rtl/eda_pixel_scanner.sv | 138 +++++++++++++
 tb/tb_eda_pixel_scanner.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eda_pixel_scanner_pkg.sv
// Shared configuration and FSM state encodings for the pixel scanner slice.
package eda_pixel_scanner_pkg;

  // Default frame geometry: address is {row, col}.
  localparam int CFG_I_WIDTH    = 8;
  localparam int CFG_J_WIDTH    = 8;
  localparam int CFG_ADDR_WIDTH = CFG_I_WIDTH + CFG_J_WIDTH;

  // Scanner FSM encodings (3-bit, legacy-compatible values).
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

endpackage

// File: rtl/eda_scan_counter.sv
// Row-major raster counter: load-zero (latching dimensions), advance with
// column wrap, and an is_last flag against the latched dimensions.
module eda_scan_counter
  import eda_pixel_scanner_pkg::*;
#(
  parameter int I_WIDTH = CFG_I_WIDTH,
  parameter int J_WIDTH = CFG_J_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_zero,
  input  logic               advance,
  input  logic [I_WIDTH-1:0] rows_in,
  input  logic [J_WIDTH-1:0] cols_in,
  output logic [I_WIDTH-1:0] row,
  output logic [J_WIDTH-1:0] col,
  output logic [I_WIDTH-1:0] nxt_row,
  output logic [J_WIDTH-1:0] nxt_col,
  output logic               is_last
);

  localparam logic [I_WIDTH-1:0] I_ONE = I_WIDTH'(1);
  localparam logic [J_WIDTH-1:0] J_ONE = J_WIDTH'(1);

  logic [I_WIDTH-1:0] rows_q, rows_d, row_q, row_d;
  logic [J_WIDTH-1:0] cols_q, cols_d, col_q, col_d;
  logic               row_last, col_last;

  assign row_last = (row_q == (rows_q - I_ONE));
  assign col_last = (col_q == (cols_q - J_ONE));
  assign is_last  = row_last && col_last;

  // Next pointer/dimension values; load_zero wins over advance.
  always_comb begin
    rows_d = rows_q;
    cols_d = cols_q;
    row_d  = row_q;
    col_d  = col_q;
    if (load_zero) begin
      rows_d = rows_in;
      cols_d = cols_in;
      row_d  = '0;
      col_d  = '0;
    end else if (advance) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_q + I_ONE;
      end else begin
        col_d = col_q + J_ONE;
      end
    end
  end

  // Pointer and latched dimension registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rows_q <= '0;
      cols_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else begin
      rows_q <= rows_d;
      cols_q <= cols_d;
      row_q  <= row_d;
      col_q  <= col_d;
    end
  end

  assign row     = row_q;
  assign col     = col_q;
  assign nxt_row = row_d;
  assign nxt_col = col_d;

endmodule

// File: rtl/eda_pixel_scanner.sv
// Raster-scan seed scheduler: walks the frame row-major, skips pixels
// flagged in the visited RAM and holds each unvisited one until consumed.
module eda_pixel_scanner
  import eda_pixel_scanner_pkg::*;
#(
  parameter int I_WIDTH    = CFG_I_WIDTH,
  parameter int J_WIDTH    = CFG_J_WIDTH,
  parameter int ADDR_WIDTH = CFG_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [I_WIDTH-1:0]    img_rows,
  input  logic [J_WIDTH-1:0]    img_cols,
  input  logic                  update_strb,
  input  logic                  visited_rdata,
  output logic                  visited_ren,
  output logic [ADDR_WIDTH-1:0] visited_raddr,
  output logic [I_WIDTH-1:0]    next_row,
  output logic [J_WIDTH-1:0]    next_col,
  output logic                  next_valid,
  output logic                  iterated_all,
  output logic                  busy
);

  logic [2:0]            state_q, state_d;
  logic                  ld_zero, adv;
  logic [I_WIDTH-1:0]    ptr_row, ptr_nrow;
  logic [J_WIDTH-1:0]    ptr_col, ptr_ncol;
  logic                  ptr_last;

  logic                  ren_q, ren_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [I_WIDTH-1:0]    nrow_q, nrow_d;
  logic [J_WIDTH-1:0]    ncol_q, ncol_d;
  logic                  nvld_q, nvld_d;
  logic                  itall_q, itall_d;
  logic                  busy_q, busy_d;

  eda_scan_counter #(
    .I_WIDTH (I_WIDTH),
    .J_WIDTH (J_WIDTH)
  ) u_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_zero (ld_zero),
    .advance   (adv),
    .rows_in   (img_rows),
    .cols_in   (img_cols),
    .row       (ptr_row),
    .col       (ptr_col),
    .nxt_row   (ptr_nrow),
    .nxt_col   (ptr_ncol),
    .is_last   (ptr_last)
  );

  // Next-state logic: start overrides everything, then consume, then scan.
  always_comb begin
    state_d = state_q;
    ld_zero = 1'b0;
    adv     = 1'b0;
    if (start) begin
      ld_zero = 1'b1;
      state_d = ((img_rows == '0) || (img_cols == '0)) ? ST_FINISH : ST_FETCH;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_FETCH: state_d = ST_CHECK;
        ST_CHECK: begin
          if (!visited_rdata) begin
            state_d = ST_HOLD;
          end else if (ptr_last) begin
            state_d = ST_FINISH;
          end else begin
            adv     = 1'b1;
            state_d = ST_FETCH;
          end
        end
        ST_HOLD: begin
          if (update_strb) begin
            if (ptr_last) begin
              state_d = ST_FINISH;
            end else begin
              adv     = 1'b1;
              state_d = ST_FETCH;
            end
          end
        end
        ST_FINISH: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Registered outputs decoded from the upcoming state and pointer, so each
  // output lines up with the state it belongs to.
  always_comb begin
    ren_d   = (state_d == ST_FETCH);
    raddr_d = ren_d ? ADDR_WIDTH'({ptr_nrow, ptr_ncol}) : '0;
    nvld_d  = (state_d == ST_HOLD);
    nrow_d  = nvld_d ? ptr_nrow : '0;
    ncol_d  = nvld_d ? ptr_ncol : '0;
    itall_d = (state_d == ST_FINISH);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ren_q   <= 1'b0;
      raddr_q <= '0;
      nrow_q  <= '0;
      ncol_q  <= '0;
      nvld_q  <= 1'b0;
      itall_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ren_q   <= ren_d;
      raddr_q <= raddr_d;
      nrow_q  <= nrow_d;
      ncol_q  <= ncol_d;
      nvld_q  <= nvld_d;
      itall_q <= itall_d;
      busy_q  <= busy_d;
    end
  end

  assign visited_ren   = ren_q;
  assign visited_raddr = raddr_q;
  assign next_row      = nrow_q;
  assign next_col      = ncol_q;
  assign next_valid    = nvld_q;
  assign iterated_all  = itall_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_eda_pixel_scanner.sv
// Directed bench for eda_pixel_scanner with a behavioural visited RAM.
module tb_eda_pixel_scanner;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  img_rows = '0;
  logic [7:0]  img_cols = '0;
  logic        update_strb = 1'b0;
  logic        visited_rdata = 1'b0;
  logic        visited_ren;
  logic [15:0] visited_raddr;
  logic [7:0]  next_row;
  logic [7:0]  next_col;
  logic        next_valid;
  logic        iterated_all;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int it_cnt = 0;
  bit vmem [0:65535];

  eda_pixel_scanner dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .img_rows      (img_rows),
    .img_cols      (img_cols),
    .update_strb   (update_strb),
    .visited_rdata (visited_rdata),
    .visited_ren   (visited_ren),
    .visited_raddr (visited_raddr),
    .next_row      (next_row),
    .next_col      (next_col),
    .next_valid    (next_valid),
    .iterated_all  (iterated_all),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Visited RAM: data valid the cycle after the read enable.
  always @(posedge clk) begin
    if (visited_ren) visited_rdata <= vmem[visited_raddr];
  end

  always @(negedge clk) begin
    if (iterated_all) it_cnt <= it_cnt + 1;
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_vmem();
    for (int i = 0; i < 65536; i++) vmem[i] = 1'b0;
  endtask

  task automatic start_frame(input int r, input int c, output int s);
    img_rows = 8'(r);
    img_cols = 8'(c);
    start    = 1'b1;
    s        = cyc;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int waited);
    waited = 0;
    while (!next_valid && waited < limit) begin
      tick();
      waited++;
    end
    if (!next_valid) check_val("wait_valid_timeout", 0, 1);
  endtask

  task automatic expect_cand(input string tag, input int r, input int c, output int waited);
    wait_valid(200, waited);
    check_val({tag, "_row"}, int'(next_row), r);
    check_val({tag, "_col"}, int'(next_col), c);
  endtask

  task automatic consume(input int gap);
    repeat (gap) tick();
    update_strb = 1'b1;
    tick();
    update_strb = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, w, it0, bad;
    int r3[5], c3[5];
    clear_vmem();

    // Reset state
    repeat (2) tick();
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_valid", int'(next_valid), 0);
    check_val("rst_itall", int'(iterated_all), 0);
    check_val("rst_ren", int'(visited_ren), 0);
    check_val("rst_raddr", int'(visited_raddr), 0);
    check_val("rst_rowcol", int'({next_row, next_col}), 0);
    reset_n = 1'b1;
    tick();

    // 2x3, nothing visited, consume 2 cycles after each candidate
    it0 = it_cnt;
    start_frame(2, 3, s);
    check_val("t1_fetch_ren", int'(visited_ren), 1);
    check_val("t1_fetch_addr", int'(visited_raddr), 0);
    check_val("t1_busy", int'(busy), 1);
    tick();
    check_val("t1_check_nv", int'(next_valid), 0);
    tick();
    check_val("t1_first_valid", int'(next_valid), 1);
    check_val("t1_first_lat", cyc - s, 3);
    for (int i = 0; i < 6; i++) begin
      expect_cand("t1_cand", i / 3, i % 3, w);
      if (i > 0) check_val("t1_gap", w, 2);
      consume(2);
      check_val("t1_drop", int'(next_valid), 0);
    end
    check_val("t1_itall", int'(iterated_all), 1);
    tick();
    check_val("t1_itall_off", int'(iterated_all), 0);
    check_val("t1_idle", int'(busy), 0);
    check_val("t1_pulses", it_cnt - it0, 1);

    // 3x3 with (0,0),(0,1),(1,1),(2,2) pre-visited
    vmem[0] = 1'b1; vmem[1] = 1'b1; vmem[257] = 1'b1; vmem[514] = 1'b1;
    r3 = '{0, 1, 1, 2, 2};
    c3 = '{2, 0, 2, 0, 1};
    start_frame(3, 3, s);
    wait_valid(50, w);
    check_val("t2_first_lat", cyc - s, 7);
    for (int i = 0; i < 5; i++) begin
      expect_cand("t2_cand", r3[i], c3[i], w);
      consume(1);
    end
    check_val("t2_fetch_last_addr", int'(visited_raddr), 514);
    tick();
    check_val("t2_check_last_nv", int'(next_valid), 0);
    check_val("t2_check_last_it", int'(iterated_all), 0);
    tick();
    check_val("t2_itall", int'(iterated_all), 1);
    check_val("t2_nv_off", int'(next_valid), 0);
    tick();
    clear_vmem();

    // Zero dimensions
    for (int k = 0; k < 2; k++) begin
      start_frame(k == 0 ? 0 : 2, k == 0 ? 3 : 0, s);
      check_val("t3_itall", int'(iterated_all), 1);
      check_val("t3_nv", int'(next_valid), 0);
      tick();
      check_val("t3_itall_off", int'(iterated_all), 0);
      check_val("t3_idle", int'(busy), 0);
      bad = 0;
      repeat (3) begin tick(); bad += int'(next_valid); end
      check_val("t3_nv_never", bad, 0);
    end

    // Restart while holding (1,1) of a 4x4 frame; new frame is 2x2
    start_frame(4, 4, s);
    for (int i = 0; i < 5; i++) begin
      expect_cand("t4_pre", i / 4, i % 4, w);
      consume(0);
    end
    expect_cand("t4_hold11", 1, 1, w);
    it0 = it_cnt;
    start_frame(2, 2, s);
    check_val("t4_abort_nv", int'(next_valid), 0);
    check_val("t4_abort_addr", int'(visited_raddr), 0);
    wait_valid(20, w);
    check_val("t4_restart_lat", cyc - s, 3);
    for (int i = 0; i < 4; i++) begin
      expect_cand("t4_cand", i / 2, i % 2, w);
      consume(0);
    end
    check_val("t4_itall", int'(iterated_all), 1);
    tick();
    check_val("t4_pulses", it_cnt - it0, 1);

    // Reset during CHECK, strobes ignored afterwards
    start_frame(2, 2, s);
    tick();
    check_val("t5_in_check", int'(dut.state_q), 2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_val("t5_state", int'(dut.state_q), 0);
    check_val("t5_outs", int'({busy, next_valid, iterated_all, visited_ren}), 0);
    check_val("t5_addr", int'(visited_raddr), 0);
    bad = 0;
    update_strb = 1'b1;
    repeat (4) begin tick(); bad += int'(busy) + int'(next_valid) + int'(visited_ren); end
    update_strb = 1'b0;
    check_val("t5_strb_ignored", bad, 0);
    start_frame(1, 1, s);
    expect_cand("t5_after", 0, 0, w);
    consume(0);
    check_val("t5_itall", int'(iterated_all), 1);
    tick();

    // Controller stalls for 50 cycles on (0,1)
    start_frame(3, 3, s);
    expect_cand("t6_c0", 0, 0, w);
    consume(0);
    expect_cand("t6_c1", 0, 1, w);
    bad = 0;
    repeat (50) begin
      tick();
      if (next_valid !== 1'b1 || next_row !== 8'd0 || next_col !== 8'd1 || visited_ren !== 1'b0) bad++;
    end
    check_val("t6_stall_stable", bad, 0);
    consume(0);
    check_val("t6_drop", int'(next_valid), 0);
    check_val("t6_fetch_addr", int'(visited_raddr), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
